layer_sequencer: RTL and testbench

Multi-pass controller for the neural-network datapath. It time-multiplexes a pool of NUM_UNITS physical neuron units across the hidden layer (HIDDEN_PASSES passes) and then the output layer (OUT_PASSES passes). For each pass it launches the neurons, collects their ready flags and strobes the result into the matching register-bank slice. After the final pass it enables the max-finder and reports completion to the top-level circuit.

---
 rtl/layer_sequencer.sv | 179 +++++++++++++++++
 tb/tb_layer_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// Multi-pass neuron-pool sequencer: hidden-layer passes, then output-layer passes, then max-finder.
// Optional watchdog on WAIT (with ERR state) enabled by defining LAYER_SEQ_WATCHDOG_EN.
module layer_sequencer #(
    parameter int unsigned NUM_UNITS      = 10,
    parameter int unsigned HIDDEN_PASSES  = 3,
    parameter int unsigned OUT_PASSES     = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    localparam int unsigned MAX_PASSES    = (HIDDEN_PASSES > OUT_PASSES) ? HIDDEN_PASSES : OUT_PASSES,
    localparam int unsigned PASS_W        = (MAX_PASSES > 1) ? $clog2(MAX_PASSES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_circuit,
    input  logic [NUM_UNITS-1:0]  ready,
    output logic                  rst_hidden_regs,
    output logic                  start_neurons,
    output logic                  ld_en,
    output logic                  ld_layer,
    output logic [PASS_W-1:0]     ld_pass,
    output logic [1:0]            ctrl_w_b_data_neuron,
    output logic                  enMax,
    output logic                  ready_circuit,
    output logic                  busy,
    output logic                  err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_LOAD  = 3'd4;
    localparam logic [2:0] S_MAX   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
`ifdef LAYER_SEQ_WATCHDOG_EN
    localparam logic [2:0] S_ERR   = 3'd7;
    localparam int unsigned WD_W   = $clog2(TIMEOUT_CYCLES + 1);
`endif

    if (NUM_UNITS < 1 || HIDDEN_PASSES < 1 || OUT_PASSES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("layer_sequencer: all parameters must be at least 1");
    end

    logic [2:0]            r_state;
    logic [PASS_W-1:0]     r_pass;
    logic                  r_layer;
    logic [NUM_UNITS-1:0]  r_mask;
`ifdef LAYER_SEQ_WATCHDOG_EN
    logic [WD_W-1:0]       r_wd;
    logic                  w_wd_expired;
`endif

    logic [NUM_UNITS-1:0]  w_mask_next;
    logic                  w_wait_done;
    logic                  w_pass_is_last;

    // The bit arriving this cycle completes WAIT without waiting for the mask register.
    assign w_mask_next    = r_mask | ready;
    assign w_wait_done    = &w_mask_next;
    assign w_pass_is_last = (32'(r_pass) + 32'd1) >= (r_layer ? OUT_PASSES : HIDDEN_PASSES);

`ifdef LAYER_SEQ_WATCHDOG_EN
    assign w_wd_expired = (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd <= '0;
        end else if (r_state == S_START) begin
            r_wd <= '0;
        end else if (r_state == S_WAIT && !w_wait_done && !w_wd_expired) begin
            r_wd <= r_wd + WD_W'(1);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pass  <= '0;
            r_layer <= 1'b0;
            r_mask  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_circuit) begin
                        r_state <= S_CLR;
                        r_layer <= 1'b0;
                        r_pass  <= '0;
                    end
                end
                S_CLR: begin
                    r_state <= S_START;
                end
                S_START: begin
                    r_mask  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_mask <= w_mask_next;
                    if (w_wait_done) begin
                        r_state <= S_LOAD;
                    end
`ifdef LAYER_SEQ_WATCHDOG_EN
                    else if (w_wd_expired) begin
                        r_state <= S_ERR;
                    end
`endif
                end
                S_LOAD: begin
                    if (!w_pass_is_last) begin
                        r_pass  <= r_pass + PASS_W'(1);
                        r_state <= S_START;
                    end else if (!r_layer) begin
                        r_layer <= 1'b1;
                        r_pass  <= '0;
                        r_state <= S_START;
                    end else begin
                        r_state <= S_MAX;
                    end
                end
                S_MAX: begin
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
`ifdef LAYER_SEQ_WATCHDOG_EN
                S_ERR: begin
                    if (start_circuit) begin
                        r_state <= S_CLR;
                        r_layer <= 1'b0;
                        r_pass  <= '0;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rst_hidden_regs      = 1'b0;
        start_neurons        = 1'b0;
        ld_en                = 1'b0;
        ld_layer             = 1'b0;
        ld_pass              = '0;
        ctrl_w_b_data_neuron = 2'b00;
        enMax                = 1'b0;
        ready_circuit        = 1'b0;
        case (r_state)
            S_CLR: rst_hidden_regs = 1'b1;
            S_START: begin
                start_neurons        = 1'b1;
                ctrl_w_b_data_neuron = {1'b0, r_layer};
            end
            S_WAIT: ctrl_w_b_data_neuron = {1'b0, r_layer};
            S_LOAD: begin
                ld_en                = 1'b1;
                ld_layer             = r_layer;
                ld_pass              = r_pass;
                ctrl_w_b_data_neuron = {1'b0, r_layer};
            end
            S_MAX:  enMax         = 1'b1;
            S_DONE: ready_circuit = 1'b1;
            default: begin
            end
        endcase
    end

`ifdef LAYER_SEQ_WATCHDOG_EN
    assign busy = (r_state != S_IDLE) && (r_state != S_ERR);
    assign err  = (r_state == S_ERR);
`else
    assign busy = (r_state != S_IDLE);
    assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: directed vector table, async-reset and watchdog sequences,
// and randomized transactions checked against a per-pass timeline model.
module tb_layer_sequencer;
    localparam int unsigned N  = 10;
    localparam int unsigned H  = 3;
    localparam int unsigned O  = 1;
    localparam int unsigned P  = H + O;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_circuit;
    logic [N-1:0]  ready;
    logic          rst_hidden_regs, start_neurons, ld_en, ld_layer;
    logic [1:0]    ld_pass, ctrl;
    logic          enMax, ready_circuit, busy, err;

    int checks = 0;
    int errors = 0;
    int dly [P][N];

    always #5 clk = ~clk;

    layer_sequencer #(
        .NUM_UNITS(N),
        .HIDDEN_PASSES(H),
        .OUT_PASSES(O),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start_circuit(start_circuit),
        .ready(ready),
        .rst_hidden_regs(rst_hidden_regs),
        .start_neurons(start_neurons),
        .ld_en(ld_en),
        .ld_layer(ld_layer),
        .ld_pass(ld_pass),
        .ctrl_w_b_data_neuron(ctrl),
        .enMax(enMax),
        .ready_circuit(ready_circuit),
        .busy(busy),
        .err(err)
    );

    // Packed order: rh sn ld ll lp[1:0] ctrl[1:0] mx rc busy err
    function automatic logic [11:0] mk(bit rh, bit sn, bit ld, bit ll, logic [1:0] lp,
                                       logic [1:0] cs, bit mx, bit rc, bit bz, bit er);
        return {rh, sn, ld, ll, lp, cs, mx, rc, bz, er};
    endfunction

    task automatic check(input string tag, input int c, input logic [11:0] exp);
        logic [11:0] act;
        act = {rst_hidden_regs, start_neurons, ld_en, ld_layer, ld_pass, ctrl,
               enMax, ready_circuit, busy, err};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d: got %03h want %03h (rh sn ld ll lp ctrl mx rc busy err)",
                     tag, c, act, exp);
        end
    endtask

    // Drives one inference whose pass k has unit u arriving in WAIT cycle dly[k][u];
    // expected outputs come from the resulting pass timeline.
    task automatic run_txn(input string tag, input bit junk, input int abort_at);
        int st [P];
        int ln [P];
        int t, tdone;
        t = 2;
        for (int k = 0; k < P; k++) begin
            ln[k] = 0;
            for (int u = 0; u < N; u++)
                if (dly[k][u] + 1 > ln[k]) ln[k] = dly[k][u] + 1;
            st[k] = t;
            t = t + ln[k] + 2;
        end
        tdone = t + 1;
        for (int c = 0; c <= tdone + 1; c++) begin
            bit rh, sn, ld, ll, mx, rc, bz;
            logic [1:0] lp, cs;
            int j;
            if (c == 0) start_circuit = 1'b1;
            else if (junk && c <= tdone) start_circuit = ($urandom_range(0, 1) == 1);
            else start_circuit = 1'b0;
            ready = junk ? N'($urandom) : '0;
            rh = (c == 1); sn = 0; ld = 0; ll = 0; lp = 2'd0; cs = 2'd0;
            for (int k = 0; k < P; k++) begin
                if (c == st[k]) sn = 1;
                if (c == st[k] + ln[k] + 1) begin
                    ld = 1;
                    ll = (k >= H);
                    lp = (k >= H) ? 2'(k - H) : 2'(k);
                end
                if (c >= st[k] && c <= st[k] + ln[k] + 1 && k >= H) cs = 2'b01;
                if (c > st[k] && c <= st[k] + ln[k]) begin
                    j = c - st[k] - 1;
                    for (int u = 0; u < N; u++)
                        ready[u] = (dly[k][u] == j) ||
                                   (dly[k][u] < j && junk && $urandom_range(0, 1) == 1);
                end
            end
            mx = (c == tdone - 1);
            rc = (c == tdone);
            bz = (c >= 1 && c <= tdone);
            @(negedge clk);
            check(tag, c, mk(rh, sn, ld, ll, lp, cs, mx, rc, bz, 0));
            if (c == abort_at) begin
                #1 rst = 1'b1;
                #1 check("async_rst", c, 12'h000);
                @(posedge clk);
                #1 rst = 1'b0;
                start_circuit = 1'b0;
                ready = '0;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        bit           start;
        logic [N-1:0] rdy;
        logic [11:0]  exp;
    } vec_t;

    vec_t tbl [17];

    initial begin
        tbl[0]  = '{1'b1, '0, mk(0,0,0,0,2'd0,2'd0,0,0,0,0)};
        tbl[1]  = '{1'b0, '0, mk(1,0,0,0,2'd0,2'd0,0,0,1,0)};
        tbl[2]  = '{1'b0, '0, mk(0,1,0,0,2'd0,2'd0,0,0,1,0)};
        tbl[3]  = '{1'b0, '1, mk(0,0,0,0,2'd0,2'd0,0,0,1,0)};
        tbl[4]  = '{1'b0, '0, mk(0,0,1,0,2'd0,2'd0,0,0,1,0)};
        tbl[5]  = '{1'b0, '0, mk(0,1,0,0,2'd0,2'd0,0,0,1,0)};
        tbl[6]  = '{1'b0, '1, mk(0,0,0,0,2'd0,2'd0,0,0,1,0)};
        tbl[7]  = '{1'b0, '0, mk(0,0,1,0,2'd1,2'd0,0,0,1,0)};
        tbl[8]  = '{1'b0, '0, mk(0,1,0,0,2'd0,2'd0,0,0,1,0)};
        tbl[9]  = '{1'b0, '1, mk(0,0,0,0,2'd0,2'd0,0,0,1,0)};
        tbl[10] = '{1'b0, '0, mk(0,0,1,0,2'd2,2'd0,0,0,1,0)};
        tbl[11] = '{1'b0, '0, mk(0,1,0,0,2'd0,2'd1,0,0,1,0)};
        tbl[12] = '{1'b0, '1, mk(0,0,0,0,2'd0,2'd1,0,0,1,0)};
        tbl[13] = '{1'b0, '0, mk(0,0,1,1,2'd0,2'd1,0,0,1,0)};
        tbl[14] = '{1'b0, '0, mk(0,0,0,0,2'd0,2'd0,1,0,1,0)};
        tbl[15] = '{1'b0, '0, mk(0,0,0,0,2'd0,2'd0,0,1,1,0)};
        tbl[16] = '{1'b0, '0, mk(0,0,0,0,2'd0,2'd0,0,0,0,0)};

        rst = 1'b1;
        start_circuit = 1'b1;
        ready = '1;
        repeat (2) @(posedge clk);
        #1 check("reset_state", 0, 12'h000);
        rst = 1'b0;
        start_circuit = 1'b0;
        ready = '0;
        @(negedge clk);
        check("after_reset", 0, 12'h000);
        @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++) begin
            start_circuit = tbl[i].start;
            ready = tbl[i].rdy;
            @(negedge clk);
            check("table", i, tbl[i].exp);
            @(posedge clk);
            #1;
        end

        // Ready bits arrive one per cycle, bit u in WAIT cycle u of every pass.
        for (int k = 0; k < P; k++)
            for (int u = 0; u < N; u++) dly[k][u] = u;
        run_txn("staggered", 1'b0, -1);

        // Reset during WAIT of pass 2, then a clean restart from CLR.
        for (int k = 0; k < P; k++)
            for (int u = 0; u < N; u++) dly[k][u] = 0;
        run_txn("pre_abort", 1'b1, 9);
        run_txn("restart", 1'b0, -1);

        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < P; k++)
                for (int u = 0; u < N; u++) dly[k][u] = $urandom_range(0, 3);
            run_txn("random", 1'b1, -1);
        end

`ifdef LAYER_SEQ_WATCHDOG_EN
        // Unit 3 never reports: eight WAIT cycles (3..10), ERR from cycle 11.
        for (int c = 0; c <= 13; c++) begin
            logic [11:0] e;
            start_circuit = (c == 0) || (c == 12);
            ready = (c >= 3) ? ~(N'(1) << 3) : '0;
            case (c)
                0:       e = mk(0,0,0,0,2'd0,2'd0,0,0,0,0);
                1:       e = mk(1,0,0,0,2'd0,2'd0,0,0,1,0);
                2:       e = mk(0,1,0,0,2'd0,2'd0,0,0,1,0);
                11, 12:  e = mk(0,0,0,0,2'd0,2'd0,0,0,0,1);
                13:      e = mk(1,0,0,0,2'd0,2'd0,0,0,1,0);
                default: e = mk(0,0,0,0,2'd0,2'd0,0,0,1,0);
            endcase
            @(negedge clk);
            check("watchdog", c, e);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        start_circuit = 1'b0;
        ready = '0;
        @(posedge clk);
        #1 rst = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
